// File: rtl/clk_enable_gen.sv
// clk_enable_gen: NUM_CH independent clock-enable dividers sharing one master clock.
// Each channel produces a registered divided clock level plus one-cycle rise/fall
// strobes one cycle ahead of the level change. Configuration changes are staged in
// a per-channel shadow and only become active at a period boundary (wrap or restart),
// so a period is never cut short or stretched by a reconfiguration.
//
// Pulse inputs (restart, cfg_load) have no handshake. Each is sampled on every clk
// edge where it is high, is acted on once per high cycle, and is ignored while
// reset is high. cfg_busy is the only back-pressure signal. It reports that a captured
// configuration is waiting for the channel's next boundary, and it never blocks a load.
module clk_enable_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 4,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV  = {4'd12, 4'd4},
  parameter logic [NUM_CH*CNT_W-1:0] DEF_HIGH = {4'd6, 4'd2},
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              restart,
  input  logic              cfg_load,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] cfg_busy,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ce_rise,
  output logic [NUM_CH-1:0] ce_fall,
  output logic              align
);

  // A period shorter than 2 cannot hold both a high and a low phase.
  function automatic logic [CNT_W-1:0] clamp_p(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(2)) ? CNT_W'(2) : p;
  endfunction

  // The high time must leave at least one low cycle and at least one high cycle.
  function automatic logic [CNT_W-1:0] clamp_h(input logic [CNT_W-1:0] h,
                                               input logic [CNT_W-1:0] p);
    if (h == '0)     return CNT_W'(1);
    else if (h >= p) return p - CNT_W'(1);
    else             return h;
  endfunction

  // Strobes describe the edge about to happen. A restart replaces that edge, and
  // reset or a stopped run produces no edge at all.
  logic strobe_en;
  assign strobe_en = run && !restart && !reset;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic             busy_q, busy_d;
    logic             clk_q, clk_d;
    logic [CNT_W-1:0] new_p;
    logic             load_me;
    logic             wrap;

    // An out-of-range cfg_sel never equals a channel index, so such a load is dropped.
    assign load_me = cfg_load && (int'(cfg_sel) == i);
    assign wrap    = run && (cnt_q == p_q - CNT_W'(1));

    // Next-state logic: count or wrap, apply the shadow at the boundary, capture new loads.
    always_comb begin
      new_p     = clamp_p(sh_div_q);
      cnt_d     = cnt_q;
      p_d       = p_q;
      h_d       = h_q;
      sh_div_d  = sh_div_q;
      sh_high_d = sh_high_q;
      busy_d    = busy_q;
      clk_d     = clk_q;
      if (restart || wrap) begin
        cnt_d  = '0;
        // The shadow value from before this edge is applied, even if a load lands now.
        if (busy_q) begin
          p_d = new_p;
          h_d = clamp_h(sh_high_q, new_p);
        end
        busy_d = 1'b0;
      end else if (run) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // The level is taken from the count and high time that are valid after this edge.
      if (restart || run) begin
        clk_d = (cnt_d < h_d);
      end
      // A load on a boundary edge stays pending for the following period.
      if (load_me) begin
        sh_div_d  = cfg_div;
        sh_high_d = cfg_high;
        busy_d    = 1'b1;
      end
    end

    // Channel state registers, reset to the clamped default configuration.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q     <= '0;
        p_q       <= clamp_p(DEF_DIV[i*CNT_W +: CNT_W]);
        h_q       <= clamp_h(DEF_HIGH[i*CNT_W +: CNT_W], clamp_p(DEF_DIV[i*CNT_W +: CNT_W]));
        sh_div_q  <= '0;
        sh_high_q <= '0;
        busy_q    <= 1'b0;
        clk_q     <= 1'b1;
      end else begin
        cnt_q     <= cnt_d;
        p_q       <= p_d;
        h_q       <= h_d;
        sh_div_q  <= sh_div_d;
        sh_high_q <= sh_high_d;
        busy_q    <= busy_d;
        clk_q     <= clk_d;
      end
    end

    assign cfg_busy[i] = busy_q;
    assign clk_out[i]  = clk_q;
    assign ce_rise[i]  = strobe_en && (cnt_q == p_q - CNT_W'(1));
    assign ce_fall[i]  = strobe_en && (cnt_q == h_q - CNT_W'(1));
  end

  assign align = &ce_rise;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen with its default two-channel configuration.
module tb_clk_enable_gen;

  logic       clk;
  logic       reset;
  logic       run;
  logic       restart;
  logic       cfg_load;
  logic [0:0] cfg_sel;
  logic [3:0] cfg_div;
  logic [3:0] cfg_high;
  logic [1:0] cfg_busy;
  logic [1:0] clk_out;
  logic [1:0] ce_rise;
  logic [1:0] ce_fall;
  logic       align;

  int n_tests = 0;
  int n_fail  = 0;

  clk_enable_gen dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .restart  (restart),
    .cfg_load (cfg_load),
    .cfg_sel  (cfg_sel),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_busy (cfg_busy),
    .clk_out  (clk_out),
    .ce_rise  (ce_rise),
    .ce_fall  (ce_fall),
    .align    (align)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Advance one edge; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; restart = 1'b1;
    cfg_load = 1'b1; cfg_sel = 1'b0; cfg_div = 4'd9; cfg_high = 4'd3;
    tick();
    tick();
    #1;
    n_tests++;
    if ({clk_out, cfg_busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_state: clk_out/busy got %b expected 1100", {clk_out, cfg_busy});
    end
    n_tests++;
    if ({ce_rise, ce_fall, align} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 00000", {ce_rise, ce_fall, align});
    end
    restart = 1'b0; cfg_load = 1'b0;
  endtask

  // Default configuration: ch0 P=4 H=2, ch1 P=12 H=6; first edge out of reset gives cnt=1.
  task automatic test_defaults();
    logic [6:0] exp;
    reset = 1'b0; run = 1'b1;
    for (int k = 0; k < 24; k++) begin
      #1;
      exp = {(k % 12) < 6, (k % 4) < 2,
             (k % 12) == 11, (k % 4) == 3,
             (k % 12) == 5,  (k % 4) == 1,
             (k % 12) == 11};
      n_tests++;
      if ({clk_out, ce_rise, ce_fall, align} !== exp) begin
        n_fail++;
        $display("FAIL defaults k=%0d: clk/rise/fall/align got %b expected %b",
                 k, {clk_out, ce_rise, ce_fall, align}, exp);
      end
      tick();
    end
  endtask

  // Load ch0 div=5 high=1 at cnt0=1; applies at the ch0 wrap.
  task automatic test_reconfig();
    logic [2:0] exp;
    tick();                                   // cnt0=1
    cfg_load = 1'b1; cfg_sel = 1'b0; cfg_div = 4'd5; cfg_high = 4'd1;
    tick();                                   // cnt0=2
    cfg_load = 1'b0;
    #1;
    n_tests++;
    if (cfg_busy !== 2'b01) begin
      n_fail++;
      $display("FAIL reconfig_busy_set: got %b expected 01", cfg_busy);
    end
    tick();                                   // cnt0=3, old period still active
    #1;
    n_tests++;
    if ({cfg_busy[0], clk_out[0], ce_rise[0]} !== 3'b101) begin
      n_fail++;
      $display("FAIL reconfig_before_wrap: busy/clk/rise got %b expected 101",
               {cfg_busy[0], clk_out[0], ce_rise[0]});
    end
    tick();                                   // wrap edge: P=5 H=1 active
    for (int j = 0; j < 10; j++) begin
      #1;
      exp = {j % 5 == 0, j % 5 == 0, j % 5 == 4};
      n_tests++;
      if ({clk_out[0], ce_fall[0], ce_rise[0]} !== exp || cfg_busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reconfig j=%0d: clk/fall/rise/busy got %b%b expected %b0",
                 j, {clk_out[0], ce_fall[0], ce_rise[0]}, cfg_busy[0], exp);
      end
      tick();
    end
  endtask

  // Clamping of loaded values, applied through restart.
  task automatic test_clamp();
    logic [2:0] exp;
    restart = 1'b1;
    #1;
    n_tests++;                                // cnt0=0 with H0=1 would strobe ce_fall0
    if ({ce_rise, ce_fall, align} !== 5'b0) begin
      n_fail++;
      $display("FAIL restart_suppress: strobes got %b expected 00000", {ce_rise, ce_fall, align});
    end
    tick();
    restart = 1'b0;
    cfg_load = 1'b1; cfg_sel = 1'b0; cfg_div = 4'd1; cfg_high = 4'd0;
    tick();
    cfg_load = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;                           // P0=2 H0=1
    for (int j = 0; j < 4; j++) begin
      #1;
      exp = {j % 2 == 0, j % 2 == 0, j % 2 == 1};
      n_tests++;
      if ({clk_out[0], ce_fall[0], ce_rise[0]} !== exp || cfg_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL clamp_low j=%0d: clk/fall/rise got %b busy %b expected %b busy 00",
                 j, {clk_out[0], ce_fall[0], ce_rise[0]}, cfg_busy, exp);
      end
      tick();
    end
    cfg_load = 1'b1; cfg_sel = 1'b0; cfg_div = 4'd3; cfg_high = 4'd7;
    tick();
    cfg_load = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;                           // P0=3 H0=2
    for (int j = 0; j < 6; j++) begin
      #1;
      exp = {j % 3 < 2, j % 3 == 1, j % 3 == 2};
      n_tests++;
      if ({clk_out[0], ce_fall[0], ce_rise[0]} !== exp) begin
        n_fail++;
        $display("FAIL clamp_high j=%0d: clk/fall/rise got %b expected %b",
                 j, {clk_out[0], ce_fall[0], ce_rise[0]}, exp);
      end
      tick();
    end
  endtask

  // Drop run at cnt1=7 for 5 cycles, then resume.
  task automatic test_run_hold();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int j = 0; j < 7; j++) tick();       // cnt1=7, cnt0=1
    run = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_tests++;
      if ({clk_out, cfg_busy, ce_rise, ce_fall, align} !== 9'b01_00_00_00_0) begin
        n_fail++;
        $display("FAIL run_hold j=%0d: clk/busy/rise/fall/align got %b expected 010000000",
                 j, {clk_out, cfg_busy, ce_rise, ce_fall, align});
      end
      tick();
    end
    run = 1'b1;
    #1;
    n_tests++;                                // still cnt1=7, cnt0=1
    if ({clk_out, ce_fall} !== 4'b0101) begin
      n_fail++;
      $display("FAIL run_resume: clk/fall got %b expected 0101", {clk_out, ce_fall});
    end
    tick();                                   // cnt1=8, cnt0=2
    #1;
    n_tests++;
    if ({clk_out, ce_rise} !== 4'b0001) begin
      n_fail++;
      $display("FAIL run_resume_8: clk/rise got %b expected 0001", {clk_out, ce_rise});
    end
    tick(); tick(); tick();                   // cnt1=11, cnt0=2
    #1;
    n_tests++;
    if ({ce_rise, align} !== 3'b111) begin
      n_fail++;
      $display("FAIL align: rise/align got %b expected 111", {ce_rise, align});
    end
  endtask

  // Restart coinciding with a second ch1 load while the first is still pending.
  task automatic test_restart_load();
    logic [6:0] exp;
    tick();                                   // both wrap to 0
    cfg_load = 1'b1; cfg_sel = 1'b1; cfg_div = 4'd8; cfg_high = 4'd3;
    tick();
    cfg_load = 1'b0;
    #1;
    n_tests++;
    if (cfg_busy !== 2'b10) begin
      n_fail++;
      $display("FAIL pend_busy: got %b expected 10", cfg_busy);
    end
    cfg_load = 1'b1; cfg_sel = 1'b1; cfg_div = 4'd6; cfg_high = 4'd2; restart = 1'b1;
    tick();
    cfg_load = 1'b0; restart = 1'b0;          // ch1 P=8 H=3, 6/2 pending
    for (int j = 0; j < 8; j++) begin
      #1;
      exp = {j < 3, j % 3 < 2, j == 7, j % 3 == 2, j == 2, j % 3 == 1, 1'b0};
      n_tests++;
      if ({clk_out, ce_rise, ce_fall, align} !== exp || cfg_busy !== 2'b10) begin
        n_fail++;
        $display("FAIL restart_load j=%0d: clk/rise/fall/align got %b busy %b expected %b busy 10",
                 j, {clk_out, ce_rise, ce_fall, align}, cfg_busy, exp);
      end
      tick();
    end
    for (int j = 0; j < 6; j++) begin         // ch1 P=6 H=2, cnt0 continues from 2
      #1;
      n_tests++;
      if (clk_out !== {j < 2, (8 + j) % 3 < 2} || cfg_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL second_apply j=%0d: clk got %b busy %b expected %b busy 00",
                 j, clk_out, cfg_busy, {j < 2, (8 + j) % 3 < 2});
      end
      tick();
    end
  endtask

  // Reset in the middle of a period with a pending load.
  task automatic test_reset_mid();
    cfg_load = 1'b1; cfg_sel = 1'b0; cfg_div = 4'd7; cfg_high = 4'd3;
    tick();
    cfg_load = 1'b0;
    tick();
    #1;
    n_tests++;
    if (cfg_busy !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_busy: got %b expected 01", cfg_busy);
    end
    reset = 1'b1; restart = 1'b1; cfg_load = 1'b1; cfg_sel = 1'b1;
    tick();
    restart = 1'b0; cfg_load = 1'b0;
    #1;
    n_tests++;
    if ({clk_out, cfg_busy, ce_rise, ce_fall, align} !== 9'b11_00_00_00_0) begin
      n_fail++;
      $display("FAIL mid_reset: clk/busy/rise/fall/align got %b expected 110000000",
               {clk_out, cfg_busy, ce_rise, ce_fall, align});
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_tests++;
      if (clk_out !== {(k % 12) < 6, (k % 4) < 2} || cfg_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL post_reset k=%0d: clk got %b busy %b expected %b busy 00",
                 k, clk_out, cfg_busy, {(k % 12) < 6, (k % 4) < 2});
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; restart = 1'b0; cfg_load = 1'b0;
    cfg_sel = 1'b0; cfg_div = 4'd0; cfg_high = 4'd0;
    test_reset();
    test_defaults();
    test_reconfig();
    test_clamp();
    test_run_hold();
    test_restart_load();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
